// File: rtl/missle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : missle_pkg                                                 |
// | Purpose  : Shared types and constants for the missile launch          |
// |            scheduler and its per-slot flight trackers.                |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package missle_pkg;

  // Screen coordinate width carried for each missile start position.
  localparam int COORD_W = 10;

  typedef enum logic {
    SCH_WAIT  = 1'b0,
    SCH_GRANT = 1'b1
  } sch_state_t;

  typedef enum logic [1:0] {
    SLOT_IDLE   = 2'd0,
    SLOT_ARMING = 2'd1,
    SLOT_FLIGHT = 2'd2
  } slot_state_t;

endpackage : missle_pkg
`default_nettype wire

// File: rtl/missle_slot_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : missle_slot_tracker                                        |
// | Purpose  : Flight state of one missile slot. After a launch the slot  |
// |            waits for explored to drop (absorbing a stale flag left by |
// |            the previous flight), then flies until explored rises.     |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module missle_slot_tracker
  import missle_pkg::*;
#(
  parameter int ARM_TIMEOUT = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic launch,
  input  logic explored,
  output logic busy
);

  localparam int CNT_W = $clog2(ARM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARM_TIMEOUT - 1);

  slot_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register and arming counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= SLOT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: ARMING gives up after ARM_TIMEOUT cycles of explored=1,
  // treating the launch as lost.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SLOT_IDLE: begin
        if (launch) begin
          state_d = SLOT_ARMING;
          cnt_d   = '0;
        end
      end
      SLOT_ARMING: begin
        if (!explored) begin
          state_d = SLOT_FLIGHT;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = SLOT_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SLOT_FLIGHT: begin
        if (explored) begin
          state_d = SLOT_IDLE;
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  assign busy = (state_q != SLOT_IDLE);

endmodule : missle_slot_tracker
`default_nettype wire

// File: rtl/missle_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : missle_scheduler                                           |
// | Purpose  : Frame-rate launch scheduler. Picks a shooter round-robin,  |
// |            assigns the lowest idle missile slot, pulses launch/grant  |
// |            and enforces a global inter-launch cooldown in frames.     |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module missle_scheduler
  import missle_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int NUM_SLOTS       = 4,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int ARM_TIMEOUT     = 8
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_clk,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_alive,
  input  logic [NUM_REQ*COORD_W-1:0]   req_x,
  input  logic [NUM_REQ*COORD_W-1:0]   req_y,
  input  logic [NUM_SLOTS-1:0]         slot_explored,
  output logic [NUM_SLOTS-1:0]         launch,
  output logic [NUM_SLOTS*COORD_W-1:0] start_x,
  output logic [NUM_SLOTS*COORD_W-1:0] start_y,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_SLOTS-1:0]         slot_busy,
  output logic [NUM_SLOTS*2-1:0]       slot_owner
);

  localparam int OWN_W  = 2;
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CD_W   = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(COOLDOWN_FRAMES);

  logic                         frame_dly_q, fe_q;
  sch_state_t                   state_q, state_d;
  logic [CD_W-1:0]              cooldown_q, cooldown_d;
  logic [OWN_W-1:0]             ptr_q, ptr_d;
  logic [OWN_W-1:0]             win_q, win_d;
  logic [SLOT_W-1:0]            slot_q, slot_d;
  logic [NUM_SLOTS*COORD_W-1:0] start_x_q, start_x_d;
  logic [NUM_SLOTS*COORD_W-1:0] start_y_q, start_y_d;
  logic [NUM_SLOTS*2-1:0]       owner_q, owner_d;

  logic [NUM_REQ-1:0] valid_req;
  logic               win_found, slot_found;
  logic [OWN_W-1:0]   win_idx, cand;
  logic [SLOT_W-1:0]  slot_idx;
  int                 cand_i;

  assign valid_req = req & req_alive;

  // All scheduler state, including the registered frame edge strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_dly_q <= 1'b0;
      fe_q        <= 1'b0;
      state_q     <= SCH_WAIT;
      cooldown_q  <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      slot_q      <= '0;
      start_x_q   <= '0;
      start_y_q   <= '0;
      owner_q     <= '0;
    end else begin
      frame_dly_q <= frame_clk;
      fe_q        <= frame_clk & ~frame_dly_q;
      state_q     <= state_d;
      cooldown_q  <= cooldown_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      slot_q      <= slot_d;
      start_x_q   <= start_x_d;
      start_y_q   <= start_y_d;
      owner_q     <= owner_d;
    end
  end

  // Round-robin winner (first valid at/after ptr) and lowest idle slot.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand_i     = 0;
    cand       = '0;
    slot_found = 1'b0;
    slot_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_i = int'(ptr_q) + k;
      if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
      cand = OWN_W'(cand_i);
      if (!win_found && valid_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!slot_busy[SLOT_W'(k)]) begin
        slot_found = 1'b1;
        slot_idx   = SLOT_W'(k);
      end
    end
  end

  // Scheduler FSM. Start coordinates and owner are captured on the fe
  // cycle so they are already stable while launch is high.
  always_comb begin
    state_d    = state_q;
    cooldown_d = cooldown_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    slot_d     = slot_q;
    start_x_d  = start_x_q;
    start_y_d  = start_y_q;
    owner_d    = owner_q;
    case (state_q)
      SCH_WAIT: begin
        if (fe_q) begin
          if (cooldown_q != '0) begin
            cooldown_d = cooldown_q - 1'b1;
          end else if (enable && win_found && slot_found) begin
            state_d = SCH_GRANT;
            win_d   = win_idx;
            slot_d  = slot_idx;
            start_x_d[slot_idx*COORD_W +: COORD_W] = req_x[win_idx*COORD_W +: COORD_W];
            start_y_d[slot_idx*COORD_W +: COORD_W] = req_y[win_idx*COORD_W +: COORD_W];
            owner_d[slot_idx*OWN_W +: OWN_W]       = win_idx;
          end
        end
      end
      SCH_GRANT: begin
        cooldown_d = CD_RELOAD;
        ptr_d      = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
        state_d    = SCH_WAIT;
      end
      default: state_d = SCH_WAIT;
    endcase
  end

  // One-cycle launch and grant pulses decoded from the grant state.
  always_comb begin
    launch = '0;
    grant  = '0;
    if (state_q == SCH_GRANT) begin
      launch[slot_q] = 1'b1;
      grant[win_q]   = 1'b1;
    end
  end

  assign start_x    = start_x_q;
  assign start_y    = start_y_q;
  assign slot_owner = owner_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    missle_slot_tracker #(
      .ARM_TIMEOUT(ARM_TIMEOUT)
    ) u_trk (
      .Clk     (Clk),
      .Reset   (Reset),
      .launch  (launch[g]),
      .explored(slot_explored[g]),
      .busy    (slot_busy[g])
    );
  end

endmodule : missle_scheduler
`default_nettype wire

// File: doc/missle_scheduler.md
Name: missle_scheduler

Overview:
- Frame-rate launch scheduler for a pool of NUM_SLOTS missile instances (one falling-missile datapath per slot).
- Arbitrates fire requests from NUM_REQ shooters (enemy sprites) round-robin.
- Allocates the lowest free slot and issues a one-cycle launch pulse with the latched start coordinates.
- Tracks per-slot flight state from each slot's explored/alive feedback and enforces a global inter-launch cooldown in frames.

Parameters:
- NUM_REQ, 4, number of requesting shooters.
- NUM_SLOTS, 4, number of missile datapath instances.
- COOLDOWN_FRAMES, 30, minimum frames between two launches (0 = launch every frame allowed).
- ARM_TIMEOUT, 8, max Clk cycles a slot waits in ARMING for explored to drop.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous active-high reset.
- frame_clk  in  1  frame strobe (~60 Hz).
- enable  in  1  game running; 0 blocks new grants, in-flight slots keep tracking.
- req  in  NUM_REQ  level fire request per shooter.
- req_alive  in  NUM_REQ  shooter alive; a request from a dead shooter is ignored.
- req_x  in  NUM_REQ*10  flattened shooter X positions; shooter i at bits [10i+9:10i].
- req_y  in  NUM_REQ*10  flattened shooter Y positions, same packing.
- slot_explored  in  NUM_SLOTS  explored flag from each missile slot.
- launch  out  NUM_SLOTS  one-cycle launch pulse per slot.
- start_x  out  NUM_SLOTS*10  per-slot start X, held until that slot's next launch.
- start_y  out  NUM_SLOTS*10  per-slot start Y, same packing.
- grant  out  NUM_REQ  one-cycle pulse to the served shooter, coincident with launch.
- slot_busy  out  NUM_SLOTS  slot not IDLE.
- slot_owner  out  NUM_SLOTS*2  index of the shooter that launched each slot.

Behaviour:
- Reset, sampled on posedge Clk:
  - outputs: launch, grant, slot_busy, start_x, start_y, slot_owner all 0.
  - internal: cooldown counter 0, round-robin pointer 0, all slots IDLE.
  - Reset overrides everything, including a launch in progress.
- Frame edge detect:
  - frame_clk_delayed <= frame_clk.
  - fe <= frame_clk & ~frame_clk_delayed, registered, so fe is high exactly one cycle.
- Scheduler FSM (SCH_WAIT, SCH_GRANT):
  - SCH_WAIT: on fe:
    - If cooldown != 0, decrement it and stay.
    - Else if enable, any valid request (req & req_alive) and any slot IDLE: latch winner w and slot s, go to SCH_GRANT.
    - Otherwise stay.
  - SCH_GRANT, one cycle:
    - launch[s] = 1 and grant[w] = 1.
    - start_x[s] = req_x[w], start_y[s] = req_y[w], values latched at the fe cycle; slot_owner[s] = w.
    - cooldown <= COOLDOWN_FRAMES.
    - Pointer <= w+1 mod NUM_REQ.
    - Return to SCH_WAIT.
  - Latency: launch is high in the cycle after fe. At most one launch per frame.
- Arbitration:
  - Winner is the first valid requester at or after the pointer, wrapping.
  - Slot choice is the lowest-index IDLE slot.
- Per-slot FSM (IDLE, ARMING, FLIGHT):
  - IDLE -> ARMING on launch[s].
  - ARMING:
    - -> FLIGHT when slot_explored[s] == 0. This absorbs a stale explored=1 left over from the previous flight.
    - -> IDLE if ARM_TIMEOUT cycles elapse with explored still 1 (lost launch).
  - FLIGHT -> IDLE when slot_explored[s] rises to 1.
  - slot_busy[s] = (state != IDLE).
- Boundary conditions:
  - All slots busy: no grant; requests stay pending and the pointer is unchanged.
  - Requester drops req before fe: not served.
  - Shooter dies in the fe cycle: not eligible.
  - enable low: cooldown still counts down on fe; no grants.
  - explored rise and launch on the same slot in the same cycle: impossible by construction, since only IDLE slots are granted.
  - COOLDOWN_FRAMES = 0: a grant is possible on every fe.
  - Cooldown counter width is clog2(COOLDOWN_FRAMES+1), minimum 1 bit.
- Arithmetic: coordinates are passed through unmodified; the Y offset is applied inside the missile datapath.

Decomposition:
- Package missle_pkg:
  - sch_state_t enum {SCH_WAIT, SCH_GRANT}.
  - slot_state_t enum {SLOT_IDLE, SLOT_ARMING, SLOT_FLIGHT}.
  - COORD_W = 10.
- Sub-module missle_slot_tracker: per-slot FSM plus arm timeout, instantiated NUM_SLOTS times via generate.
- Round-robin arbiter stays inline.

Test Plan:
- Reset mid-grant: assert Reset in the SCH_GRANT cycle -> next cycle launch=0, slot_busy=0, cooldown=0.
- Single request, COOLDOWN_FRAMES=2: req=0001, req_x[0]=100, req_y[0]=50.
  - Required: launch[0] one cycle after fe; start_x[0]=100, start_y[0]=50; grant[0]=1.
  - Next grant occurs on the third fe after the launch, not earlier.
- Round-robin, COOLDOWN_FRAMES=0: req=1111 held, explored toggles normally.
  - Required: successive grants to 0,1,2,3,0.
  - Slots used are 0,1,2,3, then the first freed slot.
- Pool exhaustion: 4 launches with explored held 0.
  - Required: slot_busy=1111 and no launch on the 5th fe.
  - Raising slot_explored[2] -> the 6th fe launches slot 2.
- Stale explored:
  - Launch slot 1 while slot_explored[1]=1; drop it after 3 cycles -> slot 1 goes to FLIGHT.
  - With explored held 1 for 8 cycles -> slot 1 returns to IDLE, slot_busy[1]=0.
- Gating: enable=0, or req=0001 with req_alive=0000 -> no launch or grant on any fe; cooldown still decrements.
